// File: rtl/io_responder.sv
// io_responder: IN/OUT/STOP handler between the core and the board I/O
// (debounced confirm button for IN, display register for OUT, halt on STOP).
module io_responder #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inop,
  input  logic              outop,
  input  logic              sleep,
  input  logic [DATA_W-1:0] out_src,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn,
  output logic              stall,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] disp,
  output logic              disp_strobe,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, WAIT_BTN, CAPTURE, HALT} state_t;
  state_t            state_q, state_d;
  logic              s1_q, s2_q, db_q, db_d, dbp_q, press, tgl, stall_c;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] in_data_q, in_data_d, disp_q, disp_d;
  logic              strobe_q, strobe_d;
  always_comb begin
    cnt_inc = cnt_q + 16'd1;
    tgl     = (s2_q != db_q) && (cnt_inc == 16'(DEBOUNCE_CYCLES));
    cnt_d   = (s2_q != db_q && !tgl) ? cnt_inc : '0;
    db_d    = db_q ^ tgl;
  end
  assign press = db_q & ~dbp_q;
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    disp_d    = disp_q;
    strobe_d  = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = sleep | inop;
        state_d = sleep ? HALT : inop ? WAIT_BTN : IDLE;
        disp_d  = (!sleep && !inop && outop) ? out_src : disp_q;
        strobe_d = !sleep && !inop && outop;
      end
      WAIT_BTN: begin
        stall_c   = 1'b1;
        in_data_d = press ? DATA_W'(sw) : in_data_q;
        state_d   = press ? CAPTURE : WAIT_BTN;
      end
      CAPTURE: state_d = IDLE;
      HALT:    stall_c = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      dbp_q     <= 1'b0;
      cnt_q     <= '0;
      in_data_q <= '0;
      disp_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= btn;
      s2_q      <= s1_q;
      db_q      <= db_d;
      dbp_q     <= db_q;
      cnt_q     <= cnt_d;
      in_data_q <= in_data_d;
      disp_q    <= disp_d;
      strobe_q  <= strobe_d;
    end
  end
  // stall is combinational from inop/sleep, so gate it to honour an immediate reset
  assign stall       = stall_c & ~rst;
  assign in_valid    = state_q == CAPTURE;
  assign halted      = state_q == HALT;
  assign in_data     = in_data_q;
  assign disp        = disp_q;
  assign disp_strobe = strobe_q;
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed bench with an in_data scoreboard for io_responder.
module tb_io_responder;
  logic        clk = 1'b0, rst = 1'b1, inop = 1'b0, outop = 1'b0, sleep = 1'b0, btn = 1'b0;
  logic [31:0] out_src = '0;
  logic [15:0] sw = '0;
  logic        stall, in_valid, disp_strobe, halted;
  logic [31:0] in_data, disp;
  int          n = 0, fails = 0, ncap = 0;
  logic [31:0] q[$];
  io_responder #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .inop(inop), .outop(outop), .sleep(sleep),
    .out_src(out_src), .sw(sw), .btn(btn), .stall(stall), .in_valid(in_valid),
    .in_data(in_data), .disp(disp), .disp_strobe(disp_strobe), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (in_valid) begin
    if (q.size() == 0) begin
      n++;
      fails++;
      $error("FAIL unexpected_in_valid observed=%h expected=none", in_data);
    end else begin
      chk("in_data", in_data, q.pop_front());
      ncap++;
    end
  end
  task automatic idle(input int k, input logic exp_stall);
    repeat (k) begin
      @(negedge clk); #1;
      chk("stall", stall, exp_stall);
      chk("no_valid", in_valid, 1'b0);
    end
  endtask
  task automatic wait_cap(input int lo, input int hi);
    int c = 0;
    forever begin
      @(negedge clk); #1;
      c++;
      if (in_valid) begin
        chk("cap_stall", stall, 1'b0);
        chk("latency", 32'(c >= lo && c <= hi), 32'd1);
        inop = 1'b0;
        return;
      end
      chk("wait_stall", stall, 1'b1);
      n++;
      assert (c < hi + 4) else begin
        fails++;
        $error("FAIL capture_timeout observed=%0d cycles expected<=%0d", c, hi);
      end
      if (c >= hi + 4) return;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", in_valid, 1'b0);
    chk("rst_in_data", in_data, 32'h0);
    chk("rst_disp", disp, 32'h0);
    chk("rst_strobe", disp_strobe, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b0;
    idle(2, 1'b0);
    // 1: basic capture
    sw = 16'h00A5;
    inop = 1'b1;
    #1 chk("idle_inop_stall", stall, 1'b1);
    q.push_back(32'h000000A5);
    idle(10, 1'b1);
    btn = 1'b1;
    wait_cap(6, 8);
    idle(2, 1'b0);
    chk("in_data_hold", in_data, 32'h000000A5);
    btn = 1'b0;
    idle(8, 1'b0);
    // 2: bounce rejected
    sw = 16'h1234;
    inop = 1'b1;
    q.push_back(32'h00001234);
    for (int i = 0; i < 10; i++) begin
      btn = ~i[0];
      idle(2, 1'b1);
    end
    btn = 1'b1;
    wait_cap(6, 8);
    btn = 1'b0;
    idle(8, 1'b0);
    // 3: level already high on entry is not a press
    btn = 1'b1;
    idle(8, 1'b0);
    inop = 1'b1;
    idle(10, 1'b1);
    btn = 1'b0;
    idle(8, 1'b1);
    sw = 16'hBEEF;
    q.push_back(32'h0000BEEF);
    btn = 1'b1;
    wait_cap(6, 8);
    btn = 1'b0;
    idle(8, 1'b0);
    // 4: OUT, held OUT, press in IDLE discarded
    out_src = 32'hDEADBEEF;
    outop = 1'b1;
    @(negedge clk); #1;
    chk("disp_out", disp, 32'hDEADBEEF);
    chk("strobe_out", disp_strobe, 1'b1);
    out_src = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("disp_held", disp, 32'hCAFEF00D);
    chk("strobe_held", disp_strobe, 1'b1);
    outop = 1'b0;
    @(negedge clk); #1;
    chk("strobe_off", disp_strobe, 1'b0);
    chk("disp_keep", disp, 32'hCAFEF00D);
    btn = 1'b1;
    idle(10, 1'b0);
    btn = 1'b0;
    idle(8, 1'b0);
    chk("ncap_after_idle_press", ncap, 32'd3);
    // 5: sleep beats inop, HALT ignores everything but rst
    sleep = 1'b1;
    inop = 1'b1;
    #1 chk("sleep_stall_comb", stall, 1'b1);
    @(negedge clk); #1;
    sleep = 1'b0;
    inop = 1'b0;
    chk("halted", halted, 1'b1);
    btn = 1'b1;
    idle(10, 1'b1);
    btn = 1'b0;
    out_src = 32'h11112222;
    outop = 1'b1;
    idle(2, 1'b1);
    chk("halt_no_strobe", disp_strobe, 1'b0);
    chk("halt_disp", disp, 32'hCAFEF00D);
    chk("still_halted", halted, 1'b1);
    outop = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_halted_clr", halted, 1'b0);
    chk("rst_halt_stall", stall, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle(8, 1'b0);
    // 6: async reset mid-wait
    inop = 1'b1;
    idle(3, 1'b1);
    btn = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_wait_stall", stall, 1'b0);
    chk("rst_wait_valid", in_valid, 1'b0);
    @(negedge clk) inop = 1'b0;
    @(negedge clk) rst = 1'b0;
    idle(12, 1'b0);
    btn = 1'b0;
    idle(8, 1'b0);
    chk("queue_empty", q.size(), 32'd0);
    chk("ncap_total", ncap, 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
